dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for the CPU data-memory port. Serves one load/store at a time over a
//   valid/ready request/response handshake with a configurable access latency. Word-organised
//   storage with byte/half/word lanes and load sign/zero extension; flags misaligned and
//   out-of-range accesses. Lets the pipeline be verified against a non-zero-latency memory.
// PARAMETERS
//   DATAW        32             data and address width
//   BASE_ADDR    32'h01000000   byte address of word 0
//   DEPTH_WORDS  1024           storage depth in 32-bit words
//   LATENCY      2              cycles from request accept to resp_valid; legal range >= 1
// PORTS
//   clock         in   1      single clock; all logic on posedge
//   reset         in   1      synchronous, active-low (0 = reset)
//   req_valid     in   1      request present
//   req_ready     out  1      responder can accept a request
//   req_rw        in   1      1 = store, 0 = load
//   req_addr      in   DATAW  byte address
//   req_size      in   2      00 byte, 01 half, 10 word, 11 illegal (funct3[1:0])
//   req_unsigned  in   1      loads: 1 = zero-extend, 0 = sign-extend (funct3[2])
//   req_wdata     in   DATAW  store data, right-aligned
//   resp_valid    out  1      response present
//   resp_ready    in   1      requester accepts response
//   resp_rdata    out  DATAW  load data, extended; 0 for stores and errors
//   resp_err      out  1      misaligned, out of range, or illegal size
// BEHAVIOUR
//   Clocking: one clock; reset is synchronous and active-low.
//   - Reset (reset==0 at posedge):
//     - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
//     - Storage contents are not cleared.
//     - An in-flight request is dropped; its store is not committed unless it was already committed.
//   - FSM:
//     - IDLE: req_ready=1. On req_valid, latch rw/addr/size/unsigned/wdata; cnt=LATENCY-1.
//       Go to WAIT if cnt>0, else go to RESP.
//     - WAIT: req_ready=0. cnt decrements each cycle; at cnt==0 go to RESP.
//     - RESP: req_ready=0, resp_valid=1. rdata/err are registered on entry and held stable
//       until resp_ready. The handshake cycle returns to IDLE.
//   - Latency: a request accepted at edge N gives resp_valid=1 after edge N+LATENCY.
//     Minimum spacing between accepts is LATENCY+1 cycles when resp_ready is tied high.
//   - req_ready is a function of state only; it never depends on req_valid.
//   - Index and offset: idx = (addr-BASE_ADDR)>>2, lane = addr[1:0].
//   - Error, checked at commit time (entry to RESP):
//     - size==11;
//     - half with addr[0]!=0;
//     - word with addr[1:0]!=0;
//     - addr<BASE_ADDR or addr-BASE_ADDR >= DEPTH_WORDS*4.
//     On error: no storage change; resp_rdata=0; resp_err=1.
//   - Store commit happens on the same edge that enters RESP.
//     - byte: writes lane = wdata[7:0].
//     - half: writes lanes {lane+1, lane} = wdata[15:0].
//     - word: writes all lanes.
//     - Other lanes are untouched.
//   - Load: reads the word at idx on the edge entering RESP, shifts right by lane*8, then
//     extends from bit 7 (byte) or 15 (half), or zero-extends when req_unsigned=1.
//   - A load issued after a completed store to the same word returns the updated data.
//   - Request inputs are ignored outside IDLE and outside req_valid&&req_ready.
// STRUCTURE
//   Shared package (mem_pkg): SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILLEGAL, RESP_IDLE/WAIT/RESP
//   state encodings, LOAD_OPCODE/STORE_OPCODE.
//   Sub-module dmem_lane_align (combinational): store lane mask and merge; load shift and extend.
//   Top holds the FSM, latency counter, request latch, storage array and error check.
// TESTING
//   1 Store word 0xDEADBEEF @0x01000000, then load word (LATENCY=2)
//     -> resp_valid 2 cycles after each accept; load rdata=0xDEADBEEF, err=0.
//   2 Store byte 0x80 @0x01000003, then load byte signed and unsigned
//     -> 0xFFFFFF80 / 0x00000080; the word now reads 0x80ADBEEF.
//   3 Load half @0x01000001; store word @0x01000002; req_size=11
//     -> err=1, rdata=0, storage unchanged.
//   4 Access @0x00FFFFFC and @BASE_ADDR+DEPTH_WORDS*4 -> err=1, no write.
//   5 Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable and req_ready=0 throughout;
//     a new req_valid is not accepted until the cycle after the response handshake.
//   6 Drop reset (reset=0) during WAIT of a store, then load the same address
//     -> old data returned; resp_valid=0 on the cycle after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory port: access sizes, responder states, opcodes and request payload.
package mem_pkg;

    localparam int unsigned MEM_DATAW = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_RESP = 2'd2
    } resp_state_e;

    localparam logic [6:0] LOAD_OPCODE  = 7'b0000011;
    localparam logic [6:0] STORE_OPCODE = 7'b0100011;

    typedef struct packed {
        logic                 rw;
        logic [MEM_DATAW-1:0] addr;
        mem_size_e            size;
        logic                 is_unsigned;
        logic [MEM_DATAW-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: merges store data into a stored word and extracts/extends load data.
module dmem_lane_align
    import mem_pkg::*;
#(
    parameter int unsigned DATAW = 32
) (
    input  logic [DATAW-1:0] word,
    input  logic [DATAW-1:0] wdata,
    input  mem_size_e        size,
    input  logic [1:0]       lane,
    input  logic             is_unsigned,
    output logic [DATAW-1:0] merged_c,
    output logic [DATAW-1:0] load_c
);
    localparam int unsigned NBYTES = DATAW / 8;

    logic [4:0]        shamt;
    logic [NBYTES-1:0] mask;
    logic [DATAW-1:0]  wshift;
    logic [DATAW-1:0]  rshift;

    // Store path: position data at its lane, then overwrite only the masked bytes.
    always_comb begin
        shamt  = {lane, 3'b000};
        wshift = wdata << shamt;
        case (size)
            SIZE_BYTE: mask = NBYTES'(1) << lane;
            SIZE_HALF: mask = NBYTES'(3) << lane;
            SIZE_WORD: mask = '1;
            default:   mask = '0;
        endcase
        merged_c = word;
        for (int b = 0; b < int'(NBYTES); b++) begin
            if (mask[b]) begin
                merged_c[b*8 +: 8] = wshift[b*8 +: 8];
            end
        end
    end

    // Load path: right-align the addressed lane, then sign- or zero-extend.
    always_comb begin
        rshift = word >> shamt;
        case (size)
            SIZE_BYTE: load_c = is_unsigned ? DATAW'(rshift[7:0])
                                            : {{(DATAW-8){rshift[7]}}, rshift[7:0]};
            SIZE_HALF: load_c = is_unsigned ? DATAW'(rshift[15:0])
                                            : {{(DATAW-16){rshift[15]}}, rshift[15:0]};
            default:   load_c = rshift;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed access latency, byte/half/word lanes,
// misalignment and range checking at commit.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned      DATAW       = 32,
    parameter logic [DATAW-1:0] BASE_ADDR   = DATAW'(32'h0100_0000),
    parameter int unsigned      DEPTH_WORDS = 1024,
    parameter int unsigned      LATENCY     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [DATAW-1:0] req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [DATAW-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DATAW-1:0] resp_rdata,
    output logic             resp_err
);
    localparam int unsigned IDXW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNTW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned SPANW = DATAW + 1;
    localparam logic [SPANW-1:0] SPAN = SPANW'(DEPTH_WORDS) << 2;

    resp_state_e      state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             accept_c;
    logic             enter_resp_c;

    mem_req_t         req_c, req_q, op_c;
    logic [DATAW-1:0] offset_c;
    logic [IDXW-1:0]  idx_c;
    logic             err_c;
    logic [DATAW-1:0] merged_c;
    logic [DATAW-1:0] load_c;

    logic [DATAW-1:0] mem_q [DEPTH_WORDS];

    // State register and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= RESP_IDLE;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_ready  <= (state_d == RESP_IDLE);
            resp_valid <= (state_d == RESP_RESP);
        end
    end

    // Next-state logic; ready depends on state only, never on req_valid.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept_c     = 1'b0;
        enter_resp_c = 1'b0;
        case (state_q)
            RESP_IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    cnt_d    = CNTW'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = RESP_WAIT;
                    end else begin
                        state_d      = RESP_RESP;
                        enter_resp_c = 1'b1;
                    end
                end
            end
            RESP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP_RESP;
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            RESP_RESP: begin
                if (resp_ready) begin
                    state_d = RESP_IDLE;
                end
            end
            default: state_d = RESP_IDLE;
        endcase
    end

    // With LATENCY==1 the commit edge is also the accept edge, so take the live request in IDLE.
    always_comb begin
        req_c.rw          = req_rw;
        req_c.addr        = req_addr;
        req_c.size        = mem_size_e'(req_size);
        req_c.is_unsigned = req_unsigned;
        req_c.wdata       = req_wdata;
        op_c              = (state_q == RESP_IDLE) ? req_c : req_q;
    end

    // Address decode and error classification.
    always_comb begin
        offset_c = op_c.addr - BASE_ADDR;
        idx_c    = offset_c[IDXW+1:2];
        err_c    = (op_c.size == SIZE_ILLEGAL)
                || ((op_c.size == SIZE_HALF) && op_c.addr[0])
                || ((op_c.size == SIZE_WORD) && (op_c.addr[1:0] != 2'b00))
                || (op_c.addr < BASE_ADDR)
                || ({1'b0, offset_c} >= SPAN);
    end

    dmem_lane_align #(
        .DATAW (DATAW)
    ) u_lane_align (
        .word        (mem_q[idx_c]),
        .wdata       (op_c.wdata),
        .size        (op_c.size),
        .lane        (op_c.addr[1:0]),
        .is_unsigned (op_c.is_unsigned),
        .merged_c    (merged_c),
        .load_c      (load_c)
    );

    // Request latch and response registers, captured on accept and on RESP entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept_c) begin
                req_q <= req_c;
            end
            if (enter_resp_c) begin
                resp_err   <= err_c;
                resp_rdata <= (err_c || op_c.rw) ? '0 : load_c;
            end
        end
    end

    // Storage is never cleared; a store commits only on a non-reset RESP entry.
    always_ff @(posedge clock) begin
        if (reset && enter_resp_c && op_c.rw && !err_c) begin
            mem_q[idx_c] <= merged_c;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with default parameters (LATENCY=2).
module tb_dmem_responder;
    import mem_pkg::*;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_rw       = rw;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
    endtask

    // One transaction with resp_ready high; lat counts edges from accept to resp_valid.
    task automatic xact(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clock);
        drive(rw, addr, size, uns, wdata);
        n = 0;
        while (!req_ready && n < 32) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 32) begin
            @(posedge clock);
            #1 lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input string tag, input logic rw, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(rw, addr, size, uns, wdata, rd, er, lat);
        check($sformatf("%s.lat", tag), lat, 32'd2);
        check($sformatf("%s.rdata", tag), rd, exp_rdata);
        check($sformatf("%s.err", tag), {31'd0, er}, {31'd0, exp_err});
    endtask

    initial begin
        int lat;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_rw       = 1'b0;
        req_addr     = '0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        resp_ready   = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", {31'd0, resp_err}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Word store/load round trip
        run("t1.st_w", 1'b1, BASE, SIZE_WORD, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        run("t1.ld_w", 1'b0, BASE, SIZE_WORD, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte store into lane 3, extended loads
        run("t2.st_b", 1'b1, BASE + 32'd3, SIZE_BYTE, 1'b0, 32'h1234_5680, 32'h0, 1'b0);
        run("t2.ld_b", 1'b0, BASE + 32'd3, SIZE_BYTE, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
        run("t2.ld_bu", 1'b0, BASE + 32'd3, SIZE_BYTE, 1'b1, 32'h0, 32'h00000080, 1'b0);
        run("t2.ld_w", 1'b0, BASE, SIZE_WORD, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
        run("t2.ld_b1", 1'b0, BASE + 32'd1, SIZE_BYTE, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0);
        run("t2.ld_hu", 1'b0, BASE + 32'd2, SIZE_HALF, 1'b1, 32'h0, 32'h000080AD, 1'b0);

        // Misaligned and illegal-size accesses
        run("t3.ld_h_mis", 1'b0, BASE + 32'd1, SIZE_HALF, 1'b0, 32'h0, 32'h0, 1'b1);
        run("t3.st_w_mis", 1'b1, BASE + 32'd2, SIZE_WORD, 1'b0, 32'h1234_5678, 32'h0, 1'b1);
        run("t3.st_ill", 1'b1, BASE, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        run("t3.ld_ill", 1'b0, BASE, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        run("t3.ld_w", 1'b0, BASE, SIZE_WORD, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
        run("t3.st_h", 1'b1, BASE + 32'd2, SIZE_HALF, 1'b0, 32'hFFFF_A5C3, 32'h0, 1'b0);
        run("t3.ld_w2", 1'b0, BASE, SIZE_WORD, 1'b0, 32'h0, 32'hA5C3BEEF, 1'b0);
        run("t3.ld_h", 1'b0, BASE + 32'd2, SIZE_HALF, 1'b0, 32'h0, 32'hFFFFA5C3, 1'b0);

        // Range boundaries
        run("t4.st_below", 1'b1, 32'h00FF_FFFC, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
        run("t4.st_above", 1'b1, 32'h0100_1000, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
        run("t4.ld_w", 1'b0, BASE, SIZE_WORD, 1'b0, 32'h0, 32'hA5C3BEEF, 1'b0);
        run("t4.st_last", 1'b1, 32'h0100_0FFC, SIZE_WORD, 1'b0, 32'h1122_3344, 32'h0, 1'b0);
        run("t4.ld_last", 1'b0, 32'h0100_0FFC, SIZE_WORD, 1'b0, 32'h0, 32'h11223344, 1'b0);
        run("t4.ld_above", 1'b0, 32'h0100_1000, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1);

        // Response back-pressure with a competing request pending
        resp_ready = 1'b0;
        @(negedge clock);
        drive(1'b0, BASE, SIZE_WORD, 1'b0, 32'h0);
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 32) begin
            @(posedge clock);
            #1 lat++;
        end
        check("t5.lat", lat, 32'd2);
        drive(1'b1, BASE, SIZE_WORD, 1'b0, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("t5.hold_valid", {31'd0, resp_valid}, 32'd1);
            check("t5.hold_rdata", resp_rdata, 32'hA5C3BEEF);
            check("t5.hold_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        check("t5.hs_valid", {31'd0, resp_valid}, 32'd0);
        check("t5.hs_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1;
        check("t5.acc_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 32) begin
            @(posedge clock);
            #1 lat++;
        end
        check("t5.st_lat", lat, 32'd2);
        check("t5.st_err", {31'd0, resp_err}, 32'd0);
        @(posedge clock);
        #1;
        run("t5.ld_w", 1'b0, BASE, SIZE_WORD, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);

        // Reset during an in-flight store: in WAIT (d=0) and on the would-be commit edge (d=1)
        for (int d = 0; d < 2; d++) begin
            @(negedge clock);
            drive(1'b1, BASE, SIZE_WORD, 1'b0, 32'h5555_5555);
            @(posedge clock);
            #1 req_valid = 1'b0;
            if (d == 1) begin
                @(posedge clock);
                #1;
            end
            reset = 1'b0;
            @(posedge clock);
            #1;
            check($sformatf("t6.%0d.resp_valid", d), {31'd0, resp_valid}, 32'd0);
            check($sformatf("t6.%0d.req_ready", d), {31'd0, req_ready}, 32'd1);
            check($sformatf("t6.%0d.resp_err", d), {31'd0, resp_err}, 32'd0);
            reset = 1'b1;
            run($sformatf("t6.%0d.ld_w", d), 1'b0, BASE, SIZE_WORD, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
